// File: rtl/biu_pkg.sv
// Shared types and constants for the bus interface unit bus master.
package biu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        T1,
        T2,
        T3,
        TW,
        T4
    } bus_state_t;

    typedef enum logic {
        RD,
        WR
    } access_kind_t;

    localparam logic [19:0] ADDR_MASK_WORD = 20'hF_FFFE;
    localparam logic [19:0] WORD_STRIDE    = 20'd2;

endpackage

// File: rtl/byte_lane_merge.sv
// Byte lane helper: replaces one byte lane of a 16-bit word and extracts a
// byte lane from the same word. lane=0 selects [7:0], lane=1 selects [15:8].
module byte_lane_merge (
    input  logic [15:0] word,
    input  logic [7:0]  lane_byte,
    input  logic        lane,
    output logic [15:0] merged,
    output logic [7:0]  extracted
);

    // Lane insert and lane extract are both pure muxing on the lane select.
    always_comb begin
        merged = word;
        if (lane) begin
            merged[15:8] = lane_byte;
        end else begin
            merged[7:0] = lane_byte;
        end
        extracted = lane ? word[15:8] : word[7:0];
    end

endmodule

// File: rtl/bus_cycle_controller.sv
// BIU bus master: turns byte/word requests at byte addresses into 16-bit
// word bus cycles (T1..T4). Odd-address words split into two word accesses,
// byte writes become read-modify-write.
// Optional macro BUS_READY_EN adds the ready input and the TW wait state.
module bus_cycle_controller
    import biu_pkg::*;
#(
    parameter int unsigned WIDTH_ADDR = 20,
    parameter int unsigned WIDTH_DATA = 16
) (
    input  logic                  clock,
    input  logic                  reset,
`ifdef BUS_READY_EN
    input  logic                  ready,
`endif
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic                  req_word,
    input  logic [WIDTH_ADDR-1:0] req_address,
    input  logic [WIDTH_DATA-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [WIDTH_DATA-1:0] rsp_rdata,
    output logic                  read_enable,
    output logic [WIDTH_ADDR-1:0] read_address,
    input  logic [WIDTH_DATA-1:0] read_data,
    output logic                  write_enable,
    output logic [WIDTH_ADDR-1:0] write_address,
    output logic [WIDTH_DATA-1:0] write_data
);

    bus_state_t             state;
    bus_state_t             state_next;

    logic                   cap_write;
    logic                   cap_word;
    logic [WIDTH_ADDR-1:0]  cap_addr;
    logic [WIDTH_DATA-1:0]  cap_wdata;

    logic [1:0]             sub_idx;
    logic [1:0]             last_idx;
    logic                   last_sub;

    logic [WIDTH_DATA-1:0]  lane_buf;
    logic [7:0]             first_byte;

    access_kind_t           kind;
    logic [WIDTH_ADDR-1:0]  word_base;
    logic [WIDTH_ADDR-1:0]  word_next;
    logic [WIDTH_ADDR-1:0]  sub_addr;
    logic                   lane;
    logic [7:0]             lane_byte;
    logic [WIDTH_DATA-1:0]  lane_word;
    logic [WIDTH_DATA-1:0]  merged;
    logic [7:0]             extracted;
    logic [WIDTH_DATA-1:0]  read_result;

    logic                   bus_go;
    logic                   accept;
    logic                   sample;
    logic                   in_cycle;

`ifdef BUS_READY_EN
    assign bus_go = ready;
`else
    assign bus_go = 1'b1;
`endif

    assign word_base = cap_addr & WIDTH_ADDR'(ADDR_MASK_WORD);
    assign word_next = word_base + WIDTH_ADDR'(WORD_STRIDE);
    assign last_sub  = (sub_idx == last_idx);
    assign accept    = (state == IDLE) && req_valid;
    assign in_cycle  = (state != IDLE);
    assign sample    = ((state == T3) || (state == TW)) && bus_go && (kind == RD);

    // Decode the current sub-access (kind, word address, byte lane) from the
    // captured request and the sub-access index.
    always_comb begin
        kind      = RD;
        sub_addr  = word_base;
        lane      = cap_addr[0];
        lane_byte = cap_wdata[7:0];
        last_idx  = 2'd0;
        if (!cap_word) begin
            // byte: read only, or read then merged write
            kind     = (cap_write && sub_idx[0]) ? WR : RD;
            last_idx = cap_write ? 2'd1 : 2'd0;
        end else if (!cap_addr[0]) begin
            kind = cap_write ? WR : RD;
        end else if (!cap_write) begin
            // odd word read: high byte of W, then low byte of W+2
            sub_addr = sub_idx[0] ? word_next : word_base;
            lane     = ~sub_idx[0];
            last_idx = 2'd1;
        end else begin
            // odd word write: RMW of W high lane, then RMW of W+2 low lane
            kind      = sub_idx[0] ? WR : RD;
            sub_addr  = sub_idx[1] ? word_next : word_base;
            lane      = ~sub_idx[1];
            lane_byte = sub_idx[1] ? cap_wdata[15:8] : cap_wdata[7:0];
            last_idx  = 2'd3;
        end
    end

    // Write sub-accesses merge into the buffered word; read sub-accesses
    // extract their lane straight from the bus.
    assign lane_word = (kind == WR) ? lane_buf : read_data;

    byte_lane_merge u_lane (
        .word      (lane_word),
        .lane_byte (lane_byte),
        .lane      (lane),
        .merged    (merged),
        .extracted (extracted)
    );

    // Assemble the response word for the final read sub-access.
    always_comb begin
        read_result = read_data;
        if (!cap_word) begin
            read_result = {8'h00, extracted};
        end else if (cap_addr[0]) begin
            read_result = {extracted, first_byte};
        end
    end

    // Bus cycle state register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state sequencing through T1..T4 per sub-access.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = req_valid ? T1 : IDLE;
            T1:      state_next = T2;
            T2:      state_next = T3;
            T3:      state_next = bus_go ? T4 : TW;
            TW:      state_next = bus_go ? T4 : TW;
            T4:      state_next = last_sub ? IDLE : T1;
            default: state_next = IDLE;
        endcase
    end

    // Request capture, sub-access counter, lane buffer and response data.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cap_write  <= 1'b0;
            cap_word   <= 1'b0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            sub_idx    <= '0;
            lane_buf   <= '0;
            first_byte <= '0;
            rsp_rdata  <= '0;
        end else begin
            if (accept) begin
                cap_write <= req_write;
                cap_word  <= req_word;
                cap_addr  <= req_address;
                cap_wdata <= req_wdata;
                sub_idx   <= '0;
            end else if ((state == T4) && !last_sub) begin
                sub_idx <= sub_idx + 2'd1;
            end
            if (sample) begin
                lane_buf   <= read_data;
                first_byte <= extracted;
                if (last_sub) begin
                    rsp_rdata <= read_result;
                end
            end
        end
    end

    assign req_ready     = (state == IDLE);
    assign rsp_valid     = (state == T4) && last_sub;
    assign read_enable   = in_cycle && (kind == RD) && (state != T4);
    assign read_address  = (in_cycle && (kind == RD)) ? sub_addr : '0;
    assign write_enable  = (kind == WR) && (state == T2);
    assign write_address = (in_cycle && (kind == WR)) ? sub_addr : '0;
    assign write_data    = !(in_cycle && (kind == WR)) ? '0 :
                           (cap_word && !cap_addr[0]) ? cap_wdata : merged;

endmodule

// File: tb/tb_bus_cycle_controller.sv
// Directed bench for bus_cycle_controller with a word memory model.
module tb_bus_cycle_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_word;
    logic [19:0] req_address;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        read_enable;
    logic [19:0] read_address;
    logic [15:0] read_data = 16'h0000;
    logic        write_enable;
    logic [19:0] write_address;
    logic [15:0] write_data;
`ifdef BUS_READY_EN
    logic        ready;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    bus_cycle_controller #(
        .WIDTH_ADDR (20),
        .WIDTH_DATA (16)
    ) dut (
        .clock         (clock),
        .reset         (reset),
`ifdef BUS_READY_EN
        .ready         (ready),
`endif
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_word      (req_word),
        .req_address   (req_address),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .read_enable   (read_enable),
        .read_address  (read_address),
        .read_data     (read_data),
        .write_enable  (write_enable),
        .write_address (write_address),
        .write_data    (write_data)
    );

    // Memory model: read data valid the cycle after read_enable is seen.
    logic [15:0] mem [logic [19:0]];

    function automatic logic [15:0] mem_at(input logic [19:0] a);
        return mem.exists(a) ? mem[a] : 16'h0000;
    endfunction

    always @(posedge clock) begin
        if (read_enable) read_data <= mem_at(read_address);
        if (write_enable) mem[write_address] = write_data;
    end

    // Bus monitor on the falling edge.
    logic        re_prev = 1'b0;
    int          re_cycles = 0;
    int          both_cnt = 0;
    int          rsp_cnt = 0;
    logic [19:0] rd_q [$];
    logic [35:0] wr_q [$];

    always @(negedge clock) begin
        if (read_enable && !re_prev) rd_q.push_back(read_address);
        if (read_enable) re_cycles++;
        if (write_enable) wr_q.push_back({write_address, write_data});
        if (read_enable && write_enable) both_cnt++;
        if (rsp_valid) rsp_cnt++;
        re_prev = read_enable;
    end

    task automatic check_value(input string tag, input logic [35:0] got, input logic [35:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        rd_q.delete();
        wr_q.delete();
        re_cycles = 0;
    endtask

    task automatic check_reads(input string tag, input int n, input logic [19:0] a0, input logic [19:0] a1);
        check_value({tag, ".nreads"}, 36'(rd_q.size()), 36'(n));
        if (n > 0 && rd_q.size() > 0) check_value({tag, ".raddr0"}, 36'(rd_q[0]), 36'(a0));
        if (n > 1 && rd_q.size() > 1) check_value({tag, ".raddr1"}, 36'(rd_q[1]), 36'(a1));
    endtask

    task automatic check_writes(input string tag, input int n, input logic [35:0] w0, input logic [35:0] w1);
        check_value({tag, ".nwrites"}, 36'(wr_q.size()), 36'(n));
        if (n > 0 && wr_q.size() > 0) check_value({tag, ".write0"}, wr_q[0], w0);
        if (n > 1 && wr_q.size() > 1) check_value({tag, ".write1"}, wr_q[1], w1);
    endtask

    // Issue one request, measure accept->rsp_valid latency, check read data.
    task automatic run_req(input string tag, input logic wr, input logic wd,
                           input logic [19:0] a, input logic [15:0] d,
                           input int exp_lat, input logic chk_rd, input logic [15:0] exp_rd);
        int  cyc;
        bit  seen;
        clear_mon();
        @(negedge clock);
        check_value({tag, ".ready_idle"}, 36'(req_ready), 36'(1));
        req_valid   = 1'b1;
        req_write   = wr;
        req_word    = wd;
        req_address = a;
        req_wdata   = d;
        @(negedge clock);
        req_valid = 1'b0;
        cyc  = 1;
        seen = 1'b0;
        check_value({tag, ".ready_busy"}, 36'(req_ready), 36'(0));
        while (!seen && cyc <= 40) begin
            if (rsp_valid) seen = 1'b1;
            else begin
                @(negedge clock);
                cyc++;
            end
        end
        check_value({tag, ".latency"}, seen ? 36'(cyc) : 36'(0), 36'(exp_lat));
        if (chk_rd) check_value({tag, ".rdata"}, 36'(rsp_rdata), 36'(exp_rd));
        @(negedge clock);
        check_value({tag, ".rsp_pulse"}, 36'(rsp_valid), 36'(0));
        check_value({tag, ".ready_after"}, 36'(req_ready), 36'(1));
    endtask

    int rsp_before;

    initial begin
        reset       = 1'b0;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_word    = 1'b0;
        req_address = '0;
        req_wdata   = '0;
`ifdef BUS_READY_EN
        ready       = 1'b1;
`endif
        repeat (3) @(negedge clock);
        check_value("rst.req_ready", 36'(req_ready), 36'(1));
        check_value("rst.rsp_valid", 36'(rsp_valid), 36'(0));
        check_value("rst.read_enable", 36'(read_enable), 36'(0));
        check_value("rst.write_enable", 36'(write_enable), 36'(0));
        check_value("rst.rsp_rdata", 36'(rsp_rdata), 36'(0));
        check_value("rst.read_address", 36'(read_address), 36'(0));
        reset = 1'b1;

        // aligned word read
        mem[20'h00010] = 16'hBEEF;
        run_req("t1", 1'b0, 1'b1, 20'h00010, 16'h0000, 4, 1'b1, 16'hBEEF);
        check_reads("t1", 1, 20'h00010, 20'h0);
        check_value("t1.re_cycles", 36'(re_cycles), 36'(3));
        check_writes("t1", 0, 36'h0, 36'h0);

        // odd word read
        mem[20'h00010] = 16'h3412;
        mem[20'h00012] = 16'h7856;
        run_req("t2", 1'b0, 1'b1, 20'h00011, 16'h0000, 8, 1'b1, 16'h5634);
        check_reads("t2", 2, 20'h00010, 20'h00012);

        // byte write to high lane (read-modify-write)
        run_req("t3", 1'b1, 1'b0, 20'h00013, 16'h00AB, 8, 1'b0, 16'h0000);
        check_reads("t3", 1, 20'h00012, 20'h0);
        check_writes("t3", 1, {20'h00012, 16'hAB56}, 36'h0);
        check_value("t3.mem", 36'(mem_at(20'h00012)), 36'(16'hAB56));
        check_value("t3.rdata_held", 36'(rsp_rdata), 36'(16'h5634));

        // odd word read across the top of the address space
        mem[20'hFFFFE] = 16'hCD00;
        mem[20'h00000] = 16'h00EF;
        run_req("t4", 1'b0, 1'b1, 20'hFFFFF, 16'h0000, 8, 1'b1, 16'hEFCD);
        check_reads("t4", 2, 20'hFFFFE, 20'h00000);

        // aligned word write
        run_req("aw", 1'b1, 1'b1, 20'h00020, 16'h1234, 4, 1'b0, 16'h0000);
        check_reads("aw", 0, 20'h0, 20'h0);
        check_writes("aw", 1, {20'h00020, 16'h1234}, 36'h0);

        // byte read of high lane, zero-extended
        run_req("br", 1'b0, 1'b0, 20'h00021, 16'h0000, 4, 1'b1, 16'h0012);

        // odd word write
        mem[20'h00030] = 16'h1111;
        mem[20'h00032] = 16'h2222;
        run_req("ow", 1'b1, 1'b1, 20'h00031, 16'hA1B2, 16, 1'b0, 16'h0000);
        check_reads("ow", 2, 20'h00030, 20'h00032);
        check_writes("ow", 2, {20'h00030, 16'hB211}, {20'h00032, 16'h22A1});

        // reset asserted during T2 of the first read of an odd word write
        clear_mon();
        rsp_before = rsp_cnt;
        @(negedge clock);
        req_valid   = 1'b1;
        req_write   = 1'b1;
        req_word    = 1'b1;
        req_address = 20'h00011;
        req_wdata   = 16'hA1B2;
        @(negedge clock);
        req_valid = 1'b0;
        @(negedge clock);
        check_value("t5.re_in_t2", 36'(read_enable), 36'(1));
        reset = 1'b0;
        @(negedge clock);
        check_value("t5.read_enable", 36'(read_enable), 36'(0));
        check_value("t5.write_enable", 36'(write_enable), 36'(0));
        check_value("t5.read_address", 36'(read_address), 36'(0));
        check_value("t5.rsp_valid", 36'(rsp_valid), 36'(0));
        check_value("t5.req_ready", 36'(req_ready), 36'(1));
        reset = 1'b1;
        repeat (20) @(negedge clock);
        check_value("t5.no_write", 36'(wr_q.size()), 36'(0));
        check_value("t5.no_rsp", 36'(rsp_cnt - rsp_before), 36'(0));

`ifdef BUS_READY_EN
        // ready low for three cycles starting at T3
        fork
            run_req("t6", 1'b0, 1'b1, 20'h00010, 16'h0000, 7, 1'b1, 16'h3412);
            begin
                repeat (3) @(negedge clock);
                ready = 1'b0;
                repeat (4) @(negedge clock);
                ready = 1'b1;
            end
        join
        check_value("t6.re_cycles", 36'(re_cycles), 36'(6));
        check_reads("t6", 1, 20'h00010, 20'h0);
`endif

        check_value("excl.enables", 36'(both_cnt), 36'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
